// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_pkg
// Purpose  : Shared state encoding, recode table and defaults for the radix-4
//            Booth multiplier sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package booth_pkg;

  // Default iteration count: 8-bit multiplier, 2 bits retired per step.
  localparam int ITER_DEFAULT  = 4;
  localparam int CNT_W_DEFAULT = 2;

  // One-hot state bit positions; outputs decode directly from these bits.
  localparam int B_IDLE   = 0;
  localparam int B_INIT   = 1;
  localparam int B_LOAD_M = 2;
  localparam int B_ADD    = 3;
  localparam int B_SHIFT  = 4;
  localparam int B_OUT_A  = 5;
  localparam int B_OUT_Q  = 6;
  localparam int B_DONE   = 7;

  localparam logic [7:0] S_IDLE   = 8'b0000_0001;
  localparam logic [7:0] S_INIT   = 8'b0000_0010;
  localparam logic [7:0] S_LOAD_M = 8'b0000_0100;
  localparam logic [7:0] S_ADD    = 8'b0000_1000;
  localparam logic [7:0] S_SHIFT  = 8'b0001_0000;
  localparam logic [7:0] S_OUT_A  = 8'b0010_0000;
  localparam logic [7:0] S_OUT_Q  = 8'b0100_0000;
  localparam logic [7:0] S_DONE   = 8'b1000_0000;

  // Recode results packed as {add, sub, sel_2m}.
  localparam logic [2:0] Q_NOP  = 3'b000;
  localparam logic [2:0] Q_ADD1 = 3'b100;
  localparam logic [2:0] Q_ADD2 = 3'b101;
  localparam logic [2:0] Q_SUB2 = 3'b011;
  localparam logic [2:0] Q_SUB1 = 3'b010;

endpackage
`default_nettype wire

// File: rtl/booth_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_ctrl_if
// Purpose  : Control/strobe bundle between the Booth sequencer and datapath.
//            master = sequencer side, slave = datapath side.
// Revision : 1.0 - initial release
// ============================================================================
interface booth_ctrl_if;
  logic       start;
  logic [2:0] q_low;
  logic       c0;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;
  logic       sel_2m;
  logic       c5;
  logic       c6;
  logic       c7;
  logic       busy;
  logic       done;

  modport master (
    input  start, q_low,
    output c0, c1, c2, c3, c4, sel_2m, c5, c6, c7, busy, done
  );

  modport slave (
    output start, q_low,
    input  c0, c1, c2, c3, c4, sel_2m, c5, c6, c7, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/booth_recode.sv
`default_nettype none
// ============================================================================
// Module   : booth_recode
// Purpose  : Radix-4 Booth digit recoder, {q[1], q[0], q[-1]} to
//            {add, sub, sel_2m}. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module booth_recode
  import booth_pkg::*;
(
  input  logic [2:0] q_low,
  output logic       add,
  output logic       sub,
  output logic       sel_2m
);

  logic [2:0] code;

  // Digit table: 0, +M, +2M, -2M, -M.
  always_comb begin
    code = Q_NOP;
    case (q_low)
      3'b001, 3'b010: code = Q_ADD1;
      3'b011:         code = Q_ADD2;
      3'b100:         code = Q_SUB2;
      3'b101, 3'b110: code = Q_SUB1;
      default:        code = Q_NOP;
    endcase
  end

  assign add    = code[2];
  assign sub    = code[1];
  assign sel_2m = code[0];

endmodule
`default_nettype wire

// File: rtl/booth_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : booth_ctrl
// Purpose  : Fixed-latency sequencer for the 8-bit radix-4 Booth multiplier.
//            One-hot state register, iteration counter and strobe decode.
// Revision : 1.0 - initial release
// ============================================================================
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int ITER  = ITER_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  booth_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  logic [7:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rc_add, rc_sub, rc_sel;

  booth_recode u_recode (
    .q_low  (bus.q_low),
    .add    (rc_add),
    .sub    (rc_sub),
    .sel_2m (rc_sel)
  );

  // Next-state and counter logic; cnt holds at ITER-1 after the last shift
  // so it never wraps inside an operation. Illegal encodings recover to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_INIT;
      S_INIT: begin
        state_d = S_LOAD_M;
        cnt_d   = '0;
      end
      S_LOAD_M: state_d = S_ADD;
      S_ADD:    state_d = S_SHIFT;
      S_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_OUT_A;
        end else begin
          state_d = S_ADD;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_OUT_A:  state_d = S_OUT_Q;
      S_OUT_Q:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and counter registers, asynchronously cleared by active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single-bit decodes of the one-hot register keep these strobes glitch-free.
  assign bus.c0     = state_q[B_INIT];
  assign bus.c1     = state_q[B_INIT];
  assign bus.c2     = state_q[B_LOAD_M];
  assign bus.c5     = state_q[B_SHIFT];
  assign bus.c6     = state_q[B_OUT_A];
  assign bus.c7     = state_q[B_OUT_Q];
  assign bus.done   = state_q[B_DONE];
  assign bus.busy   = ~state_q[B_IDLE];

  // Add/subtract strobes are only meaningful while in ADD.
  assign bus.c3     = state_q[B_ADD] & rc_add;
  assign bus.c4     = state_q[B_ADD] & rc_sub;
  assign bus.sel_2m = state_q[B_ADD] & rc_sel;

endmodule
`default_nettype wire

// File: tb/tb_booth_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_ctrl
// Purpose  : Self-checking bench for booth_ctrl using an expected-vector queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  booth_ctrl_if bus ();

  booth_ctrl #(.ITER(4), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Output vector layout: {c0,c1,c2,c3,c4,sel_2m,c5,c6,c7,busy,done}
  localparam logic [10:0] V_C0   = 11'h400;
  localparam logic [10:0] V_C1   = 11'h200;
  localparam logic [10:0] V_C2   = 11'h100;
  localparam logic [10:0] V_C3   = 11'h080;
  localparam logic [10:0] V_C4   = 11'h040;
  localparam logic [10:0] V_SEL  = 11'h020;
  localparam logic [10:0] V_C5   = 11'h010;
  localparam logic [10:0] V_C6   = 11'h008;
  localparam logic [10:0] V_C7   = 11'h004;
  localparam logic [10:0] V_BUSY = 11'h002;
  localparam logic [10:0] V_DONE = 11'h001;

  logic [10:0] sb[$];

  function automatic logic [10:0] sample();
    return {bus.c0, bus.c1, bus.c2, bus.c3, bus.c4, bus.sel_2m,
            bus.c5, bus.c6, bus.c7, bus.busy, bus.done};
  endfunction

  // Booth digit table as strobes.
  function automatic logic [10:0] add_vec(input logic [2:0] q);
    logic [10:0] r;
    case (q)
      3'b001, 3'b010: r = V_C3;
      3'b011:         r = V_C3 | V_SEL;
      3'b100:         r = V_C4 | V_SEL;
      3'b101, 3'b110: r = V_C4;
      default:        r = 11'h000;
    endcase
    return r;
  endfunction

  // codes[11:9] is the digit for the first ADD, codes[2:0] for the last.
  function automatic logic [2:0] qlow_at(input int j, input logic [11:0] codes);
    if (j == 3 || j == 5 || j == 7 || j == 9)
      return codes[11 - 3 * ((j - 3) / 2) -: 3];
    return 3'($urandom);
  endfunction

  // Expected vectors for one operation: INIT .. DONE, then one IDLE cycle.
  task automatic push_op(input logic [11:0] codes);
    sb.push_back(V_C0 | V_C1 | V_BUSY);
    sb.push_back(V_C2 | V_BUSY);
    for (int i = 0; i < 4; i++) begin
      sb.push_back(V_BUSY | add_vec(codes[11 - 3 * i -: 3]));
      sb.push_back(V_C5 | V_BUSY);
    end
    sb.push_back(V_C6 | V_BUSY);
    sb.push_back(V_C7 | V_BUSY);
    sb.push_back(V_DONE | V_BUSY);
    sb.push_back(11'h000);
  endtask

  task automatic step(input logic st, input logic [2:0] q);
    @(posedge clk);
    #1;
    bus.start = st;
    bus.q_low = q;
  endtask

  task automatic test_reset();
    logic [10:0] got;
    #12;
    got = sample();
    checks++;
    if (got !== 11'h000) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", got, 11'h000);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 3'($urandom));
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== 11'h000) begin
        errors++;
        $display("FAIL idle_after_reset cyc=%0d got=%b exp=%b", j, got, 11'h000);
      end
    end
  endtask

  task automatic test_silent();
    logic [10:0] got, exp;
    int c5_cnt = 0, busy_cnt = 0, done_j = -1;
    push_op(12'b000_000_000_000);
    bus.start = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      step(1'b0, qlow_at(j, 12'b000_000_000_000));
      @(negedge clk);
      got = sample();
      exp = sb.pop_front();
      if (bus.c5)   c5_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.done) done_j = j;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL silent cyc=k+%0d got=%b exp=%b", j, got, exp);
      end
    end
    checks++;
    if (c5_cnt != 4) begin
      errors++;
      $display("FAIL silent_c5_count got=%0d exp=4", c5_cnt);
    end
    checks++;
    if (done_j != 13) begin
      errors++;
      $display("FAIL silent_done_cycle got=k+%0d exp=k+13", done_j);
    end
    checks++;
    if (busy_cnt != 13) begin
      errors++;
      $display("FAIL silent_busy_cycles got=%0d exp=13", busy_cnt);
    end
  endtask

  task automatic test_mult3();
    logic [10:0] got, exp;
    logic [11:0] codes = 12'b110_000_000_000;
    push_op(codes);
    bus.start = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      step(1'b0, qlow_at(j, codes));
      @(negedge clk);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mult3 cyc=k+%0d got=%b exp=%b", j, got, exp);
      end
    end
  endtask

  task automatic test_sweep();
    logic [10:0] got, exp;
    logic [11:0] codes;
    int both = 0;
    for (int op = 0; op < 2; op++) begin
      codes = (op == 0) ? 12'b000_001_010_011 : 12'b100_101_110_111;
      push_op(codes);
      bus.start = 1'b1;
      for (int j = 1; j <= 14; j++) begin
        step(1'b0, qlow_at(j, codes));
        @(negedge clk);
        got = sample();
        exp = sb.pop_front();
        if (bus.c3 && bus.c4) both++;
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL sweep op=%0d cyc=k+%0d q=%b got=%b exp=%b",
                   op, j, bus.q_low, got, exp);
        end
      end
    end
    checks++;
    if (both != 0) begin
      errors++;
      $display("FAIL sweep_c3_c4_overlap got=%0d exp=0", both);
    end
  endtask

  task automatic test_start_ignored();
    logic [10:0] got, exp;
    logic [11:0] codes = 12'b011_100_001_110;
    int c5_cnt = 0, done_cnt = 0;
    push_op(codes);
    for (int j = 0; j < 4; j++) sb.push_back(11'h000);
    bus.start = 1'b1;
    for (int j = 1; j <= 18; j++) begin
      step(j == 6, qlow_at(j, codes));
      @(negedge clk);
      got = sample();
      exp = sb.pop_front();
      if (bus.c5)   c5_cnt++;
      if (bus.done) done_cnt++;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL start_ignored cyc=k+%0d got=%b exp=%b", j, got, exp);
      end
    end
    checks++;
    if (c5_cnt != 4 || done_cnt != 1) begin
      errors++;
      $display("FAIL start_ignored_counts got=c5:%0d done:%0d exp=c5:4 done:1",
               c5_cnt, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] got, exp;
    logic [11:0] ca = 12'b001_011_101_000;
    logic [11:0] cb = 12'b110_100_010_111;
    int done_at[$];
    push_op(ca);
    push_op(cb);
    sb.push_back(11'h000);
    sb.push_back(11'h000);
    bus.start = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      step(j <= 20, (j > 14) ? qlow_at(j - 14, cb) : qlow_at(j, ca));
      @(negedge clk);
      got = sample();
      exp = sb.pop_front();
      if (bus.done) done_at.push_back(j);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back cyc=k+%0d got=%b exp=%b", j, got, exp);
      end
    end
    bus.start = 1'b0;
    checks++;
    if (done_at.size() != 2) begin
      errors++;
      $display("FAIL b2b_done_count got=%0d exp=2", done_at.size());
    end else if (done_at[1] - done_at[0] != 14) begin
      errors++;
      $display("FAIL b2b_done_spacing got=%0d exp=14", done_at[1] - done_at[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] got, exp;
    logic [11:0] codes = 12'b010_011_100_101;
    push_op(codes);
    bus.start = 1'b1;
    for (int j = 1; j <= 2; j++) begin
      step(1'b0, qlow_at(j, codes));
      @(negedge clk);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid_pre cyc=k+%0d got=%b exp=%b", j, got, exp);
      end
    end
    sb.delete();
    #1;
    reset = 1'b0;
    #1;
    got = sample();
    checks++;
    if (got !== 11'h000) begin
      errors++;
      $display("FAIL reset_mid_async got=%b exp=%b", got, 11'h000);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 3'($urandom));
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== 11'h000) begin
        errors++;
        $display("FAIL reset_mid_quiet cyc=%0d got=%b exp=%b", j, got, 11'h000);
      end
    end
    push_op(codes);
    bus.start = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      step(1'b0, qlow_at(j, codes));
      @(negedge clk);
      got = sample();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_mid_restart cyc=k+%0d got=%b exp=%b", j, got, exp);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.q_low = 3'b000;
    test_reset();
    test_silent();
    test_mult3();
    test_sweep();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
